// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared definitions for the SPI frame controller: frame
//                geometry, command/data byte field positions and the
//                controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Frame geometry: one command byte followed by one data byte, MSB first.
    localparam int FRAME_BITS = 16;
    localparam int CMD_MSB    = 15;
    localparam int CMD_LSB    = 8;
    localparam int DATA_MSB   = 7;
    localparam int DATA_LSB   = 0;

    // Width of the shared timing counter (covers both half-period and gap).
    localparam int TICK_CNT_W = 8;

    // Controller state encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SCK_LO = 3'd2,
        ST_SCK_HI = 3'd3,
        ST_HOLD   = 3'd4,
        ST_GAP    = 3'd5
    } spi_state_e;

    // True for every state in which chip select is asserted.
    function automatic logic frame_active(input spi_state_e st);
        return (st == ST_SETUP) || (st == ST_SCK_LO) ||
               (st == ST_SCK_HI) || (st == ST_HOLD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_half_tick.sv
`default_nettype none
// ============================================================================
//  Module      : spi_half_tick
//  Description : Loadable down-counter that issues a one-cycle tick when it
//                reaches zero and then reloads. A load (issued on every state
//                entry) restarts the interval, so the tick lands exactly
//                load_val+1 cycles after the load.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                load          - restart the interval with load_val
//                load_val      - interval length minus one
//                tick          - high in the last cycle of the interval
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_half_tick #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt == '0) begin
            cnt <= load_val;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
//  Module      : spi_controller
//  Description : 16-bit SPI mode-3 (CPOL=1, CPHA=1) frame controller. One
//                start request sends tx_word MSB first on PICO while the
//                word returned on POCI is captured into rx_word.
//  Ports       : CLK, RST      - clock, synchronous active-high reset
//                start         - frame request (accepted when idle)
//                tx_word       - frame to send, {cmd, data}
//                busy          - frame or inter-frame gap in progress
//                done          - one-cycle pulse when CS deasserts
//                rx_word       - last complete captured word
//                SCK, CS, PICO - SPI outputs (all registered)
//                POCI          - SPI input
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_controller
    import spi_pkg::*;
#(
    parameter int HALF_DIV = 2,
    parameter int GAP_CYC  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_word,
    output logic                  busy,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rx_word,
    output logic                  SCK,
    output logic                  CS,
    output logic                  PICO,
    input  logic                  POCI
);

    spi_state_e              state;
    spi_state_e              next_state;
    logic                    tick;
    logic                    state_load;
    logic [TICK_CNT_W-1:0]   load_val;
    logic [3:0]              bit_cnt;
    logic [FRAME_BITS-1:0]   tx_sh;
    logic [FRAME_BITS-1:0]   rx_sh;
    logic                    accept;
    logic                    shift_out;
    logic                    sample_in;
    logic                    frame_end;

    // ------------------------------------------------------------------
    // Next-state logic. Timed states leave on the tick of the shared
    // counter. The last gap cycle doubles as the idle sampling point, so a
    // start held high chains frames with exactly GAP_CYC CS-high cycles.
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_SETUP;
            ST_SETUP:  if (tick)  next_state = ST_SCK_LO;
            ST_SCK_LO: if (tick)  next_state = ST_SCK_HI;
            ST_SCK_HI: if (tick)  next_state = (bit_cnt == 4'(FRAME_BITS - 1)) ? ST_HOLD : ST_SCK_LO;
            ST_HOLD:   if (tick)  next_state = ST_GAP;
            ST_GAP:    if (tick)  next_state = start ? ST_SETUP : ST_IDLE;
            default:              next_state = ST_IDLE;
        endcase
    end

    assign state_load = (next_state != state);
    assign load_val   = (next_state == ST_GAP) ? TICK_CNT_W'(GAP_CYC - 1)
                                               : TICK_CNT_W'(HALF_DIV - 1);

    assign accept    = (next_state == ST_SETUP)  && (state != ST_SETUP);
    assign shift_out = (state == ST_SCK_HI)      && (next_state == ST_SCK_LO);
    assign sample_in = (state == ST_SCK_LO)      && (next_state == ST_SCK_HI);
    assign frame_end = (state == ST_HOLD)        && (next_state == ST_GAP);

    spi_half_tick #(
        .CNT_W    (TICK_CNT_W)
    ) u_half_tick (
        .clk      (CLK),
        .rst      (RST),
        .load     (state_load),
        .load_val (load_val),
        .tick     (tick)
    );

    // PICO is the top bit of the transmit shifter, so it only moves on a
    // load or on the edge that drives SCK low.
    assign PICO = tx_sh[FRAME_BITS-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            CS      <= 1'b1;
            SCK     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_word <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
        end else begin
            state <= next_state;
            // Outputs are decoded from next_state so they are registered and
            // line up with the state they belong to.
            CS    <= ~frame_active(next_state);
            SCK   <= (next_state != ST_SCK_LO);
            busy  <= (next_state != ST_IDLE);
            done  <= frame_end;

            if (accept) begin
                tx_sh   <= tx_word;
                bit_cnt <= '0;
            end else if (shift_out) begin
                tx_sh   <= {tx_sh[FRAME_BITS-2:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
            end

            // Raw POCI capture on the edge that drives SCK high.
            if (sample_in) begin
                rx_sh <= {rx_sh[FRAME_BITS-2:0], POCI};
            end

            if (frame_end) begin
                rx_word <= rx_sh;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_controller
//  Description : Self-checking bench for spi_controller. Instance A runs
//                HALF_DIV=2/GAP_CYC=3 with a selectable POCI source
//                (loopback, tied 1, tied 0, mode-3 peripheral model);
//                instance B runs HALF_DIV=1 in loopback.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_controller;

    localparam int H_A = 2;
    localparam int G_A = 3;
    localparam int H_B = 1;
    localparam int G_B = 2;
    localparam logic [15:0] PER_WORD = 16'h3C81;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, start_b;
    logic [15:0] tx_word;
    logic        busy_a, done_a, sck_a, cs_a, pico_a, poci_a;
    logic        busy_b, done_b, sck_b, cs_b, pico_b, poci_b;
    logic [15:0] rx_a, rx_b;
    logic [1:0]  mode;
    logic        sel;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    spi_controller #(.HALF_DIV(H_A), .GAP_CYC(G_A)) dut_a (
        .CLK(clk), .RST(rst), .start(start_a), .tx_word(tx_word),
        .busy(busy_a), .done(done_a), .rx_word(rx_a),
        .SCK(sck_a), .CS(cs_a), .PICO(pico_a), .POCI(poci_a)
    );

    spi_controller #(.HALF_DIV(H_B), .GAP_CYC(G_B)) dut_b (
        .CLK(clk), .RST(rst), .start(start_b), .tx_word(tx_word),
        .busy(busy_b), .done(done_b), .rx_word(rx_b),
        .SCK(sck_b), .CS(cs_b), .PICO(pico_b), .POCI(poci_b)
    );

    // ---------------- peripheral model (mode 3) on instance A -----------
    logic        per_poci = 1'b0;
    logic [15:0] per_sh = 16'h0;
    logic [15:0] per_rx = 16'h0;
    logic        per_prev_sck = 1'b1;
    logic        per_prev_cs  = 1'b1;

    always @(posedge clk) begin
        #1;
        if (per_prev_cs === 1'b1 && cs_a === 1'b0) begin
            per_sh = PER_WORD;
            per_rx = 16'h0;
        end
        // Drive on the leading (falling) edge, capture on the trailing edge.
        if (cs_a === 1'b0 && per_prev_sck === 1'b1 && sck_a === 1'b0) begin
            per_poci = per_sh[15];
            per_sh   = {per_sh[14:0], 1'b0};
        end
        if (cs_a === 1'b0 && per_prev_sck === 1'b0 && sck_a === 1'b1)
            per_rx = {per_rx[14:0], pico_a};
        per_prev_sck = sck_a;
        per_prev_cs  = cs_a;
    end

    assign poci_a = (mode == 2'd0) ? pico_a :
                    (mode == 2'd1) ? 1'b1   :
                    (mode == 2'd2) ? 1'b0   : per_poci;
    assign poci_b = pico_b;

    // ---------------- bus monitor on the selected instance --------------
    logic        m_cs, m_sck, m_pico, m_busy, m_done;
    logic [15:0] m_rx;
    assign m_cs   = sel ? cs_b   : cs_a;
    assign m_sck  = sel ? sck_b  : sck_a;
    assign m_pico = sel ? pico_b : pico_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_done = sel ? done_b : done_a;
    assign m_rx   = sel ? rx_b   : rx_a;

    int          falls = 0, rises = 0, stray = 0;
    int          high_run = 0, low_run = 0, last_gap = 0, last_low = 0;
    int          last_falls = 0, last_rises = 0, cs_fall_cnt = 0;
    logic [15:0] bits = 16'h0, last_pico = 16'h0;
    logic        prev_sck = 1'b1, prev_cs = 1'b1;

    always @(posedge clk) begin
        #1;
        if (prev_cs === 1'b1 && m_cs === 1'b0) begin
            last_gap = high_run;
            high_run = 0;
            low_run  = 0;
            falls    = 0;
            rises    = 0;
            bits     = 16'h0;
            cs_fall_cnt++;
        end
        if (prev_cs === 1'b0 && m_cs === 1'b1) begin
            last_low   = low_run;
            last_falls = falls;
            last_rises = rises;
            last_pico  = bits;
        end
        if (m_cs === 1'b1) high_run++; else low_run++;
        if (prev_sck === 1'b1 && m_sck === 1'b0) begin
            if (m_cs === 1'b1) stray++; else falls++;
        end
        if (prev_sck === 1'b0 && m_sck === 1'b1) begin
            if (m_cs === 1'b1) stray++;
            else begin
                rises++;
                bits = {bits[14:0], m_pico};
            end
        end
        prev_sck = m_sck;
        prev_cs  = m_cs;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- one complete frame with timing checks -------------
    task automatic run_frame(input bit use_b, input logic [15:0] word,
                             input logic [15:0] exp_rx, input int h,
                             input int g, input string tag);
        int n;
        logic [15:0] want;
        @(negedge clk);
        tx_word = word;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        exp_q.push_back(exp_rx);
        @(negedge clk);                  // cycle t0+1
        start_a = 1'b0;
        start_b = 1'b0;
        tx_word = ~word;                 // must not disturb the frame
        n = 1;
        total++;
        if (m_cs !== 1'b0 || m_busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_start cs=%b busy=%b want cs=0 busy=1", tag, m_cs, m_busy);
        end
        while (m_done !== 1'b1 && n < 40*h + 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != 1 + 34*h) begin
            bad++;
            $display("FAIL %s_done_time got=t0+%0d want=t0+%0d", tag, n, 1 + 34*h);
        end
        want = exp_q.pop_front();
        total++;
        if (m_rx !== want) begin
            bad++;
            $display("FAIL %s_rx got=%h want=%h", tag, m_rx, want);
        end
        @(negedge clk);
        n++;
        total++;
        if (m_done !== 1'b0) begin
            bad++;
            $display("FAIL %s_done_pulse got=%b want=0", tag, m_done);
        end
        while (m_busy !== 1'b0 && n < 40*h + g + 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != 1 + 34*h + g) begin
            bad++;
            $display("FAIL %s_busy_fall got=t0+%0d want=t0+%0d", tag, n, 1 + 34*h + g);
        end
        total++;
        if (last_falls != 16 || last_rises != 16) begin
            bad++;
            $display("FAIL %s_sck_edges falls=%0d rises=%0d want 16/16", tag, last_falls, last_rises);
        end
        total++;
        if (last_low != 34*h) begin
            bad++;
            $display("FAIL %s_cs_low got=%0d want=%0d", tag, last_low, 34*h);
        end
        total++;
        if (m_rx !== want) begin
            bad++;
            $display("FAIL %s_rx_hold got=%h want=%h", tag, m_rx, want);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({cs_a, sck_a, pico_a, busy_a, done_a} !== 5'b11000) begin
            bad++;
            $display("FAIL reset_a_ctrl got=%b want=11000", {cs_a, sck_a, pico_a, busy_a, done_a});
        end
        total++;
        if (rx_a !== 16'h0000 || rx_b !== 16'h0000) begin
            bad++;
            $display("FAIL reset_rx got=%h/%h want=0000/0000", rx_a, rx_b);
        end
        total++;
        if ({cs_b, sck_b, pico_b, busy_b, done_b} !== 5'b11000) begin
            bad++;
            $display("FAIL reset_b_ctrl got=%b want=11000", {cs_b, sck_b, pico_b, busy_b, done_b});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (cs_a !== 1'b1 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle cs=%b busy=%b want cs=1 busy=0", cs_a, busy_a);
        end
    endtask

    task automatic test_loopback;
        mode = 2'd0;
        run_frame(1'b0, 16'hA55A, 16'hA55A, H_A, G_A, "loop_a55a");
        total++;
        if (last_pico !== 16'hA55A) begin
            bad++;
            $display("FAIL loop_pico_bits got=%b want=1010010101011010", last_pico);
        end
        run_frame(1'b0, 16'h0FF1, 16'h0FF1, H_A, G_A, "loop_0ff1");
    endtask

    task automatic test_const_poci;
        mode = 2'd1;
        run_frame(1'b0, 16'h0000, 16'hFFFF, H_A, G_A, "poci_one");
        mode = 2'd2;
        run_frame(1'b0, 16'hFFFF, 16'h0000, H_A, G_A, "poci_zero");
    endtask

    task automatic test_peripheral;
        mode = 2'd3;
        run_frame(1'b0, 16'hC35A, PER_WORD, H_A, G_A, "periph");
        total++;
        if (per_rx[15:8] !== 8'hC3 || per_rx[7:0] !== 8'h5A) begin
            bad++;
            $display("FAIL periph_seen got cmd=%h data=%h want cmd=c3 data=5a", per_rx[15:8], per_rx[7:0]);
        end
        mode = 2'd0;
    endtask

    task automatic test_back_to_back;
        int n;
        int fall0;
        logic [15:0] want;
        fall0 = cs_fall_cnt;
        @(negedge clk);
        tx_word = 16'h1E2D;
        start_a = 1'b1;
        exp_q.push_back(16'h1E2D);
        @(negedge clk);
        tx_word = 16'hB4C3;              // picked up by the chained frame
        exp_q.push_back(16'hB4C3);
        n = 0;
        while (done_a !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        want = exp_q.pop_front();
        total++;
        if (done_a !== 1'b1 || rx_a !== want) begin
            bad++;
            $display("FAIL b2b_first done=%b rx=%h want done=1 rx=%h", done_a, rx_a, want);
        end
        n = 0;
        while (cs_a !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        start_a = 1'b0;
        total++;
        if (last_gap != G_A) begin
            bad++;
            $display("FAIL b2b_gap got=%0d want=%0d", last_gap, G_A);
        end
        n = 0;
        while (done_a !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        want = exp_q.pop_front();
        total++;
        if (done_a !== 1'b1 || rx_a !== want) begin
            bad++;
            $display("FAIL b2b_second done=%b rx=%h want done=1 rx=%h", done_a, rx_a, want);
        end
        n = 0;
        while (busy_a !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        total++;
        if (cs_fall_cnt - fall0 != 2) begin
            bad++;
            $display("FAIL b2b_frames got=%0d want=2", cs_fall_cnt - fall0);
        end
    endtask

    task automatic test_start_while_busy;
        int n;
        int fall0;
        logic [15:0] want;
        fall0 = cs_fall_cnt;
        @(negedge clk);
        tx_word = 16'h5AA5;
        start_a = 1'b1;
        exp_q.push_back(16'h5AA5);
        @(negedge clk);
        start_a = 1'b0;
        repeat (20) @(negedge clk);
        start_a = 1'b1;                  // mid-frame pulse
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (done_a !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        want = exp_q.pop_front();
        total++;
        if (done_a !== 1'b1 || rx_a !== want) begin
            bad++;
            $display("FAIL busy_pulse_rx done=%b rx=%h want done=1 rx=%h", done_a, rx_a, want);
        end
        start_a = 1'b1;                  // pulse in the first gap cycle
        @(negedge clk);
        start_a = 1'b0;
        repeat (100) @(negedge clk);
        total++;
        if (cs_fall_cnt - fall0 != 1 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL busy_pulse_frames got=%0d busy=%b want=1 busy=0", cs_fall_cnt - fall0, busy_a);
        end
    endtask

    task automatic test_reset_mid_frame;
        int n;
        int stray0;
        bit saw_done;
        stray0 = stray;
        @(negedge clk);
        tx_word = 16'h7E81;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (falls < 8 && n < 200) begin @(negedge clk); n++; end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({cs_a, sck_a, pico_a, busy_a, done_a} !== 5'b11000) begin
            bad++;
            $display("FAIL midreset_ctrl got=%b want=11000", {cs_a, sck_a, pico_a, busy_a, done_a});
        end
        total++;
        if (rx_a !== 16'h0000) begin
            bad++;
            $display("FAIL midreset_rx got=%h want=0000", rx_a);
        end
        rst = 1'b0;
        // CS and SCK may rise together on the reset edge; not a bus error.
        @(negedge clk);
        stray = stray0;
        saw_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (done_a === 1'b1 || cs_a !== 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        total++;
        if (saw_done) begin
            bad++;
            $display("FAIL midreset_no_done got=activity want=quiet");
        end
        run_frame(1'b0, 16'h96C3, 16'h96C3, H_A, G_A, "after_reset");
    endtask

    task automatic test_half_div1;
        @(negedge clk);
        sel = 1'b1;
        run_frame(1'b1, 16'h8001, 16'h8001, H_B, G_B, "half1");
        total++;
        if (last_pico !== 16'h8001) begin
            bad++;
            $display("FAIL half1_pico_bits got=%h want=8001", last_pico);
        end
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic test_no_stray;
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL sck_while_cs_high got=%0d want=0", stray);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        tx_word = 16'h0000;
        mode    = 2'd0;
        sel     = 1'b0;
        test_reset();
        test_loopback();
        test_const_poci();
        test_peripheral();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_frame();
        test_half_div1();
        test_no_stray();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter HALF_DIV, default 2: CLK cycles per SCK half-period; legal range 1..255.
REQ-002 Parameter GAP_CYC, default 2: CLK cycles CS stays high after a frame before the next frame may start; legal range 1..255.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request one frame; sampled only in IDLE.
REQ-006 tx_word  input  16  frame to send; cmd byte in [15:8], data byte in [7:0]; MSB first.
REQ-007 busy  output  1  frame or inter-frame gap in progress.
REQ-008 done  output  1  one-cycle pulse at frame end.
REQ-009 rx_word  output  16  word captured from POCI, MSB first.
REQ-010 SCK  output  1  SPI clock, mode 3 (CPOL=1, CPHA=1), idles high.
REQ-011 CS  output  1  chip select, active-low, idles high.
REQ-012 PICO  output  1  controller-to-peripheral data.
REQ-013 POCI  input  1  peripheral-to-controller data; tri-stated by peripheral while CS high.

Function
REQ-014 States: IDLE, SETUP, SCK_LO, SCK_HI, HOLD, GAP; one half-period counter, one 4-bit bit counter.
REQ-015 IDLE + start=1 (cycle t0): latch tx_word into shift register, enter SETUP; CS=0 and busy=1 from t0+1.
REQ-016 SETUP: CS low, SCK high for HALF_DIV cycles; PICO = tx bit 15.
REQ-017 Each bit: SCK_LO for HALF_DIV cycles then SCK_HI for HALF_DIV cycles; 16 bits; first SCK fall at t0+1+HALF_DIV.
REQ-018 PICO changes only in the cycle SCK goes low; bit n (15 down to 0) is driven during SCK_LO/SCK_HI of bit 15-n.
REQ-019 POCI sampled on the CLK edge that drives SCK 0->1, shifted into rx shift register LSB-in; no synchronizer.
REQ-020 After the 16th SCK_HI: HOLD for HALF_DIV cycles with SCK high and CS low.
REQ-021 CS rises at t0+1+34*HALF_DIV; same cycle done=1 and rx_word updates to the full 16-bit capture.
REQ-022 rx_word holds its value until the next done or reset.
REQ-023 GAP: CS high, SCK high, for GAP_CYC cycles; busy falls at t0+1+34*HALF_DIV+GAP_CYC; IDLE reached that cycle.
REQ-024 start outside IDLE is ignored; start held high yields back-to-back frames separated by exactly GAP_CYC CS-high cycles.
REQ-025 tx_word changes after t0 do not affect the frame in progress.
REQ-026 Exactly 16 SCK falling and 16 rising edges per frame; no SCK edges while CS high.

Reset
REQ-027 RST=1 at any edge, including mid-frame: state IDLE, CS=1, SCK=1, PICO=0, busy=0, done=0, rx_word=16'h0000, counters cleared.
REQ-028 A frame aborted by reset produces no done pulse; CS rises the cycle after RST is sampled.

Structure
REQ-029 Shared package spi_pkg holds FRAME_BITS=16, CMD/DATA byte field positions, and the state enum.
REQ-030 One sub-module, spi_half_tick: loadable down-counter issuing a one-cycle tick every HALF_DIV cycles, cleared on state entry.

Verification
REQ-031 Loopback PICO->POCI, tx_word=16'hA55A, HALF_DIV=2 -> done at t0+69, rx_word=16'hA55A, PICO bit sequence 1010010101011010.
REQ-032 POCI tied 1, tx_word=16'h0000 -> rx_word=16'hFFFF; POCI tied 0 -> rx_word=16'h0000; 16 SCK falls per frame counted.
REQ-033 Model peripheral returning 16'h3C81 on POCI per mode 3 -> rx_word=16'h3C81; peripheral sees cmd 8'h(tx[15:8]), data 8'h(tx[7:0]).
REQ-034 start held high, GAP_CYC=3 -> two frames, CS high exactly 3 cycles between; start pulsed while busy -> no extra frame.
REQ-035 RST asserted at bit 7 -> CS=1, SCK=1 next cycle, no done, following frame correct.
REQ-036 HALF_DIV=1 -> CS low 34 cycles, SCK toggles every cycle, loopback 16'h8001 returns 16'h8001.
